// File: rtl/video_timing_if.sv
// Video timing bundle carried from the timing generator to the downstream
// foreground, background and pixel-mixer stages.
//
// Signals:
//   xp         game column 0..255, 0 outside the game area
//   yp         game row 0..239, 0 outside the active lines
//   visible    current clock lies inside the 256x240 game area
//   writable   vertical blank, CPU VRAM writes permitted
//   hsync      VGA horizontal sync, active low
//   vsync      VGA vertical sync, active low
//   vblank_irq one-clock pulse at the start of vertical blank
//
// Modports: master drives the bundle (the timing generator), slave consumes it.
interface video_timing_if;
   logic [7:0] xp;
   logic [7:0] yp;
   logic       visible;
   logic       writable;
   logic       hsync;
   logic       vsync;
   logic       vblank_irq;

   modport master (
      output xp, yp, visible, writable, hsync, vsync, vblank_irq
   );

   modport slave (
      input  xp, yp, visible, writable, hsync, vsync, vblank_irq
   );
endinterface

// File: rtl/video_timing.sv
// Video timing generator for the GPU pipeline.
//
// One clock is two VGA pixels; a frame is H_TOTAL clocks x V_TOTAL lines
// (400 x 525 at the default parameters). A 256-column game area is placed at
// X_OFFSET inside the active part of each line, and each game row is shown on
// two consecutive VGA lines.
//
// Ports:
//   clk  GPU clock
//   rst  synchronous active-high reset, restarts the frame at (0,0)
//   vid  master side of video_timing_if: xp, yp, visible, writable, hsync,
//        vsync, vblank_irq (all registered, all describing the current (h,v))
module video_timing #(
   parameter int H_VISIBLE = 320,
   parameter int H_FRONT   = 8,
   parameter int H_SYNC    = 48,
   parameter int H_BACK    = 24,
   parameter int X_OFFSET  = 32,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic           clk,
   input  logic           rst,
   video_timing_if.master vid
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   // Decode is done on counters widened to 12 bits so that X_OFFSET+256 and
   // every sync boundary can be represented even when the totals use 10 bits.
   localparam int DW = 12;
   localparam logic [DW-1:0] X_START  = DW'(X_OFFSET);
   localparam logic [DW-1:0] X_END    = DW'(X_OFFSET + 256);
   localparam logic [DW-1:0] HS_START = DW'(H_VISIBLE + H_FRONT);
   localparam logic [DW-1:0] HS_END   = DW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [DW-1:0] V_ACT    = DW'(V_VISIBLE);
   localparam logic [DW-1:0] VS_START = DW'(V_VISIBLE + V_FRONT);
   localparam logic [DW-1:0] VS_END   = DW'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [HW-1:0] h;
   logic [HW-1:0] h_next;
   logic [VW-1:0] v;
   logic [VW-1:0] v_next;
   logic [DW-1:0] hn;
   logic [DW-1:0] vn;
   logic          in_x;
   logic          in_y;

   always_comb begin
      h_next = h + HW'(1);
      v_next = v;
      if (h == HW'(H_TOTAL - 1)) begin
         h_next = '0;
         if (v == VW'(V_TOTAL - 1)) begin
            v_next = '0;
         end else begin
            v_next = v + VW'(1);
         end
      end
   end

   // Outputs are decoded from the next counter values so that, once
   // registered, they line up exactly with the counters they describe.
   assign hn   = DW'(h_next);
   assign vn   = DW'(v_next);
   assign in_x = (hn >= X_START) && (hn < X_END);
   assign in_y = (vn < V_ACT);

   always_ff @(posedge clk) begin
      if (rst) begin
         h              <= '0;
         v              <= '0;
         vid.xp         <= '0;
         vid.yp         <= '0;
         vid.visible    <= 1'b0;
         vid.writable   <= 1'b0;
         vid.hsync      <= 1'b1;
         vid.vsync      <= 1'b1;
         vid.vblank_irq <= 1'b0;
      end else begin
         h              <= h_next;
         v              <= v_next;
         vid.xp         <= in_x ? 8'(hn - X_START) : 8'd0;
         // Dropping bit 0 makes each game row span two VGA lines.
         vid.yp         <= in_y ? vn[8:1] : 8'd0;
         vid.visible    <= in_x && in_y;
         vid.writable   <= !in_y;
         vid.hsync      <= !((hn >= HS_START) && (hn < HS_END));
         vid.vsync      <= !((vn >= VS_START) && (vn < VS_END));
         vid.vblank_irq <= (hn == '0) && (vn == V_ACT);
      end
   end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-parameter instance for line-level timing
// and a reduced-height instance whose whole frame fits in a short run, both
// checked every cycle against an arithmetic frame-position model.
module tb_video_timing;

   typedef struct packed {
      logic [7:0] xp;
      logic [7:0] yp;
      logic       visible;
      logic       writable;
      logic       hsync;
      logic       vsync;
      logic       irq;
   } outs_t;

   localparam outs_t RST_OUT = '{xp: 8'd0, yp: 8'd0, visible: 1'b0, writable: 1'b0,
                                 hsync: 1'b1, vsync: 1'b1, irq: 1'b0};

   // Reduced instance: 268 clocks x 14 lines = 3752 clocks per frame.
   localparam int S_HV = 260, S_HF = 2, S_HS = 4, S_HB = 2, S_XO = 2;
   localparam int S_VV = 8,   S_VF = 2, S_VS = 2, S_VB = 2;
   localparam int S_FRAME = 3752;

   logic clk = 1'b0;
   logic rst_d = 1'b1;
   logic rst_s = 1'b1;

   always #5 clk = ~clk;

   video_timing_if vif_d ();
   video_timing_if vif_s ();

   video_timing dut_d (
      .clk (clk),
      .rst (rst_d),
      .vid (vif_d)
   );

   video_timing #(
      .H_VISIBLE (S_HV), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
      .X_OFFSET  (S_XO),
      .V_VISIBLE (S_VV), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
   ) dut_s (
      .clk (clk),
      .rst (rst_s),
      .vid (vif_s)
   );

   outs_t act_d, act_s;
   assign act_d = {vif_d.xp, vif_d.yp, vif_d.visible, vif_d.writable,
                   vif_d.hsync, vif_d.vsync, vif_d.vblank_irq};
   assign act_s = {vif_s.xp, vif_s.yp, vif_s.visible, vif_s.writable,
                   vif_s.hsync, vif_s.vsync, vif_s.vblank_irq};

   int n_cmp = 0;
   int n_bad = 0;
   int n_print = 0;

   // Model state: clocks elapsed since the last reset edge.
   int t_d = 0, t_s = 0;
   bit mv_d = 0, mv_s = 0;
   bit ir_d = 0, ir_s = 0;

   always @(posedge clk) begin
      if (rst_d) begin
         t_d <= 0; ir_d <= 1'b1; mv_d <= 1'b1;
      end else if (mv_d) begin
         t_d <= t_d + 1; ir_d <= 1'b0;
      end
      if (rst_s) begin
         t_s <= 0; ir_s <= 1'b1; mv_s <= 1'b1;
      end else if (mv_s) begin
         t_s <= t_s + 1; ir_s <= 1'b0;
      end
   end

   // Outputs for the frame position t, derived from the timing rules directly.
   function automatic outs_t model(int t, int hv, int hf, int hs, int hb, int xo,
                                   int vv, int vf, int vs, int vb);
      outs_t o;
      int ht, vt, h, v;
      bit ax, ay;
      ht = hv + hf + hs + hb;
      vt = vv + vf + vs + vb;
      h  = t % ht;
      v  = (t / ht) % vt;
      ax = (h >= xo) && (h < xo + 256);
      ay = (v < vv);
      o.xp       = ax ? 8'(h - xo) : 8'd0;
      o.yp       = ay ? 8'(v / 2) : 8'd0;
      o.visible  = ax && ay;
      o.writable = !ay;
      o.hsync    = !((h >= hv + hf) && (h < hv + hf + hs));
      o.vsync    = !((v >= vv + vf) && (v < vv + vf + vs));
      o.irq      = (h == 0) && (v == vv);
      return o;
   endfunction

   task automatic check_outs(string nm, int t, outs_t act, outs_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_print < 40) begin
            n_print++;
            $display("FAIL %s t=%0d: got xp=%0d yp=%0d vis=%b wr=%b hs=%b vs=%b irq=%b, want xp=%0d yp=%0d vis=%b wr=%b hs=%b vs=%b irq=%b",
                     nm, t, act.xp, act.yp, act.visible, act.writable, act.hsync, act.vsync, act.irq,
                     exp.xp, exp.yp, exp.visible, exp.writable, exp.hsync, exp.vsync, exp.irq);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mv_d)
         check_outs("model_d", t_d, act_d,
                    ir_d ? RST_OUT : model(t_d, 320, 8, 48, 24, 32, 480, 10, 2, 33));
      if (mv_s)
         check_outs("model_s", t_s, act_s,
                    ir_s ? RST_OUT : model(t_s, S_HV, S_HF, S_HS, S_HB, S_XO, S_VV, S_VF, S_VS, S_VB));
   end

   task automatic lit(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int vis_s[2], irq_s[2], hsl_s[2], vsl_s[2], wr_act_s[2];
      int irq_t[$];
      int vis_d_line0, hsl_d_line0, hs_first_d, hs_first_s;
      int f, hpos, vpos;
      for (int k = 0; k < 2; k++) begin
         vis_s[k] = 0; irq_s[k] = 0; hsl_s[k] = 0; vsl_s[k] = 0; wr_act_s[k] = 0;
      end
      vis_d_line0 = 0; hsl_d_line0 = 0; hs_first_d = -1; hs_first_s = -1;

      // Hold reset for several edges: outputs must sit at reset values.
      repeat (4) @(negedge clk);
      lit("rst_hold_hsync", int'(vif_d.hsync), 1);
      lit("rst_hold_xp", int'(vif_d.xp), 0);
      rst_d = 1'b0;
      rst_s = 1'b0;

      // Two full frames of the reduced instance; line-level checks on default.
      for (int i = 0; i < 2 * S_FRAME; i++) begin
         if (i > 0) @(negedge clk);
         if (t_s != i) begin
            lit("model_sync", t_s, i);
            break;
         end
         f    = i / S_FRAME;
         hpos = i % 268;
         vpos = (i / 268) % 14;
         if (vif_s.visible) vis_s[f]++;
         if (vif_s.vblank_irq) begin irq_s[f]++; irq_t.push_back(i); end
         if (!vif_s.hsync) begin hsl_s[f]++; if (hs_first_s < 0) hs_first_s = hpos; end
         if (!vif_s.vsync) vsl_s[f]++;
         if (vpos < S_VV && vif_s.writable) wr_act_s[f]++;
         if (i < 400) begin
            if (vif_d.visible) vis_d_line0++;
            if (!vif_d.hsync) begin hsl_d_line0++; if (hs_first_d < 0) hs_first_d = i; end
         end
         case (i)
            0:   begin lit("d0_hsync", int'(vif_d.hsync), 1); lit("d0_writable", int'(vif_d.writable), 0); end
            31:  lit("d31_visible", int'(vif_d.visible), 0);
            32:  begin lit("d32_visible", int'(vif_d.visible), 1); lit("d32_xp", int'(vif_d.xp), 0);
                       lit("d32_yp", int'(vif_d.yp), 0); end
            39:  lit("d39_xp", int'(vif_d.xp), 7);
            287: begin lit("d287_xp", int'(vif_d.xp), 255); lit("d287_visible", int'(vif_d.visible), 1); end
            288: begin lit("d288_visible", int'(vif_d.visible), 0); lit("d288_xp", int'(vif_d.xp), 0); end
            375: lit("d375_hsync", int'(vif_d.hsync), 0);
            376: lit("d376_hsync", int'(vif_d.hsync), 1);
            432: lit("d_v1_yp", int'(vif_d.yp), 0);
            832: begin lit("d_v2_yp", int'(vif_d.yp), 1); lit("d_v2_visible", int'(vif_d.visible), 1); end
            1878: begin lit("s_v7_yp", int'(vif_s.yp), 3); lit("s_v7_visible", int'(vif_s.visible), 1); end
            2143: begin lit("s_v7end_writable", int'(vif_s.writable), 0); lit("s_v7end_yp", int'(vif_s.yp), 3); end
            2144: begin lit("s_v8_writable", int'(vif_s.writable), 1); lit("s_v8_yp", int'(vif_s.yp), 0);
                        lit("s_v8_irq", int'(vif_s.vblank_irq), 1); end
            2145: lit("s_v8h1_irq", int'(vif_s.vblank_irq), 0);
            2680: lit("s_v10_vsync", int'(vif_s.vsync), 0);
            3216: lit("s_v12_vsync", int'(vif_s.vsync), 1);
            3752: begin lit("s_wrap_writable", int'(vif_s.writable), 0); lit("s_wrap_visible", int'(vif_s.visible), 0); end
            default: ;
         endcase
      end

      lit("d_line0_visible_clocks", vis_d_line0, 256);
      lit("d_line0_hsync_low", hsl_d_line0, 48);
      lit("d_hsync_start", hs_first_d, 328);
      lit("s_hsync_start", hs_first_s, 262);
      for (int k = 0; k < 2; k++) begin
         lit($sformatf("s_f%0d_visible_clocks", k), vis_s[k], 256 * S_VV);
         lit($sformatf("s_f%0d_irq_count", k), irq_s[k], 1);
         lit($sformatf("s_f%0d_hsync_low", k), hsl_s[k], 4 * 14);
         lit($sformatf("s_f%0d_vsync_low", k), vsl_s[k], 2 * 268);
         lit($sformatf("s_f%0d_writable_active", k), wr_act_s[k], 0);
      end
      if (irq_t.size() == 2) lit("s_frame_period", irq_t[1] - irq_t[0], S_FRAME);
      else lit("s_irq_times", irq_t.size(), 2);

      // Run into the third frame to v=11, h=263: inside both syncs.
      for (int i = 0; i < 5000 && t_s != 2 * S_FRAME + 11 * 268 + 263; i++) @(negedge clk);
      lit("s_midsync_reach", t_s, 2 * S_FRAME + 11 * 268 + 263);
      lit("s_midsync_hsync", int'(vif_s.hsync), 0);
      lit("s_midsync_vsync", int'(vif_s.vsync), 0);
      rst_d = 1'b1;
      rst_s = 1'b1;
      @(negedge clk);
      rst_d = 1'b0;
      rst_s = 1'b0;
      lit("s_rst_hsync", int'(vif_s.hsync), 1);
      lit("s_rst_vsync", int'(vif_s.vsync), 1);
      lit("s_rst_writable", int'(vif_s.writable), 0);
      lit("d_rst_visible", int'(vif_d.visible), 0);
      @(negedge clk);
      lit("s_restart1_visible", int'(vif_s.visible), 0);
      @(negedge clk);
      lit("s_restart2_visible", int'(vif_s.visible), 1);
      lit("s_restart2_xp", int'(vif_s.xp), 0);
      repeat (29) @(negedge clk);
      lit("d_restart31_visible", int'(vif_d.visible), 0);
      @(negedge clk);
      lit("d_restart32_visible", int'(vif_d.visible), 1);
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Generates all video timing for the GPU pipeline and sits directly upstream of the foreground, background and pixel-mixer stages.
- Runs on the 12.5875 MHz GPU clock, where one clock equals two VGA pixels. A frame is 400 clocks × 525 lines.
- Produces the game-space pixel coordinates (xp, yp) for a 256×240 screen, with each game line shown on two VGA lines.
- Also produces the visible and writable qualifiers, active-low VGA syncs, and a once-per-frame vblank pulse for the CPU interrupt.

Parameters:
- H_VISIBLE, 320, active clocks per line.
- H_FRONT, 8, horizontal front porch in clocks.
- H_SYNC, 48, horizontal sync width in clocks.
- H_BACK, 24, horizontal back porch in clocks.
- X_OFFSET, 32, clock at which game column 0 starts (centres 256 columns in 320).
- V_VISIBLE, 480, active VGA lines.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- clk  input  1  GPU clock, 12.5875 MHz.
- rst  input  1  synchronous active-high reset.
- xp  output  8  game column 0..255; 0 outside the game area.
- yp  output  8  game row 0..239; 0 outside the active lines.
- visible  output  1  current clock is inside the 256×240 game area.
- writable  output  1  vertical blank; CPU VRAM writes are permitted.
- hsync  output  1  VGA horizontal sync, active low.
- vsync  output  1  VGA vertical sync, active low.
- vblank_irq  output  1  one-clock pulse at the start of vertical blank.

Behaviour:
- Internal counters:
  - h runs 0..H_TOTAL-1, where H_TOTAL = 400 at defaults (9 bits).
  - v runs 0..V_TOTAL-1, where V_TOTAL = 525 at defaults (10 bits).
- Counter update every clk:
  - h increments by 1.
  - When h = H_TOTAL-1, h wraps to 0 and v increments.
  - When h = H_TOTAL-1 and v = V_TOTAL-1, both wrap to 0 on the same edge.
- All outputs are registered and are computed from the next (h,v). In any cycle, every output therefore describes the (h,v) currently held in the counters. There is no skew between outputs.
- Decode, with A = X_OFFSET ≤ h < X_OFFSET+256:
  - visible = A and v < V_VISIBLE.
  - xp = (h − X_OFFSET)[7:0] when A, else 0.
  - yp = v[8:1] when v < V_VISIBLE, else 0. Each yp value spans exactly two consecutive v lines.
  - writable = v ≥ V_VISIBLE. It holds for the whole line, including hblank of those lines.
  - hsync = 0 for H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC (328..375 at defaults), else 1.
  - vsync = 0 for V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC (490..491 at defaults), else 1.
  - vblank_irq = 1 only when h = 0 and v = V_VISIBLE.
- Reset:
  - rst is sampled on the clk rising edge and has priority over counting.
  - Forces h = 0 and v = 0.
  - Output values on the cycle after the reset edge: xp = 0, yp = 0, visible = 0, writable = 0, hsync = 1, vsync = 1, vblank_irq = 0.
  - Asserting rst mid-frame, including mid-sync, restarts the frame at (0,0) on the next edge with no glitch beyond that one-cycle transition.
  - Holding rst keeps all counters and outputs at the reset values.
- Counting resumes on the first edge with rst = 0. The first visible pixel (xp = 0, yp = 0) appears X_OFFSET clocks after reset release.
- Counter widths are derived from the totals with $clog2. No arithmetic may overflow at any parameter set whose totals fit in 10 bits.
- Frame period is exactly H_TOTAL×V_TOTAL = 210000 clocks (≈59.94 Hz).

Test Plan:
- Reset, release, then run 40 clocks → outputs hold reset values until h = 32. At h = 32: visible = 1, xp = 0, yp = 0. At h = 39: xp = 7.
- Run to h = 287 then h = 288 on v = 0 → at h = 287: xp = 255, visible = 1. At h = 288: visible = 0, xp = 0.
- Scan lines 0..479 → yp = 0 on v = 0 and v = 1, yp = 1 on v = 2, yp = 239 on v = 478 and v = 479. At v = 480: writable = 1, yp = 0, and vblank_irq pulses for exactly one clock at h = 0.
- Check syncs over a full frame → hsync low exactly 48 clocks per line, starting at h = 328. vsync low exactly 2 lines (v = 490, 491). vblank_irq count = 1 per frame.
- Run two full frames → visible asserted exactly 256×480 = 122880 clocks per frame. Frame period is 210000 clocks. writable is low throughout v = 0..479.
- Assert rst for 1 clock at v = 491, h = 350 (during both syncs) → next cycle hsync = 1, vsync = 1, writable = 0. Counting restarts from (0,0), and visible first rises 32 clocks later.
